// File: rtl/pwl_lerp_ctrl.sv
// Piecewise-linear evaluator front end: scans a breakpoint table for the segment
// holding x, hands the segment to an external float lerp unit, and returns y (with clamp/NaN handling).
module pwl_lerp_ctrl #(
  parameter int S       = 32,
  parameter int N       = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [S-1:0]  wr_x,
  input  logic [S-1:0]  wr_y,
  output logic          tbl_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [S-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [S-1:0]  out_y,
  output logic [1:0]    out_flag,
  output logic          out_tmo,
  output logic          lerp_start,
  output logic [S-1:0]  lerp_x1,
  output logic [S-1:0]  lerp_x2,
  output logic [S-1:0]  lerp_y1,
  output logic [S-1:0]  lerp_y2,
  output logic [S-1:0]  lerp_x,
  input  logic [S-1:0]  lerp_y,
  input  logic          lerp_done
);

  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [S-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [S-1:0] SIGN_BIT = {1'b1, {(S-1){1'b0}}};

  localparam logic [1:0] FLAG_INTERP = 2'b00;
  localparam logic [1:0] FLAG_LOW    = 2'b01;
  localparam logic [1:0] FLAG_HIGH   = 2'b10;
  localparam logic [1:0] FLAG_BAD    = 2'b11;

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [S-1:0]  xs [N];
  logic [S-1:0]  ys [N];
  logic [S-1:0]  x_q;
  logic [AW-1:0] idx;
  logic [TW-1:0] timer;

  // Order-preserving integer key: -0 folds onto +0 so the two compare equal.
  function automatic logic [S-1:0] f_key(input logic [S-1:0] a);
    logic [S-1:0] v;
    v = (a == SIGN_BIT) ? '0 : a;
    return v[S-1] ? ~v : (v | SIGN_BIT);
  endfunction

  function automatic logic f_lt(input logic [S-1:0] a, input logic [S-1:0] b);
    return f_key(a) < f_key(b);
  endfunction

  function automatic logic f_is_nan(input logic [S-1:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      // NOTE: the table is a register file, not a RAM, precisely so reset can clear it.
      for (int i = 0; i < N; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
      x_q        <= '0;
      idx        <= '0;
      timer      <= '0;
      tbl_busy   <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_flag   <= FLAG_INTERP;
      out_tmo    <= 1'b0;
      lerp_start <= 1'b0;
      lerp_x1    <= '0;
      lerp_x2    <= '0;
      lerp_y1    <= '0;
      lerp_y2    <= '0;
      lerp_x     <= '0;
    end else begin
      // NOTE: default-low here makes lerp_start a single-cycle pulse without extra state.
      lerp_start <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_en && (int'(wr_addr) < N)) begin
            xs[wr_addr] <= wr_x;
            ys[wr_addr] <= wr_y;
          end
          if (in_valid && in_ready) begin
            x_q      <= in_x;
            idx      <= '0;
            in_ready <= 1'b0;
            tbl_busy <= 1'b1;
            if (f_is_nan(in_x)) begin
              out_y     <= QNAN;
              out_flag  <= FLAG_BAD;
              out_tmo   <= 1'b0;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          if (f_lt(x_q, xs[idx])) begin
            if (idx == '0) begin
              out_y     <= ys[0];
              out_flag  <= FLAG_LOW;
              out_tmo   <= 1'b0;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // Table is strictly increasing, so xs[idx-1] <= x < xs[idx] and x2-x1 != 0.
              lerp_x1    <= xs[idx - 1'b1];
              lerp_x2    <= xs[idx];
              lerp_y1    <= ys[idx - 1'b1];
              lerp_y2    <= ys[idx];
              lerp_x     <= x_q;
              lerp_start <= 1'b1;
              state      <= ISSUE;
            end
          end else if (idx == AW'(N - 1)) begin
            out_y     <= ys[N-1];
            out_flag  <= FLAG_HIGH;
            out_tmo   <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (lerp_done) begin
            out_y     <= lerp_y;
            out_flag  <= FLAG_INTERP;
            out_tmo   <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESP;
          end else if ((TIMEOUT > 0) && (timer == TW'(TIMEOUT - 1))) begin
            out_y     <= QNAN;
            out_flag  <= FLAG_BAD;
            out_tmo   <= 1'b1;
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            tbl_busy  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_lerp_ctrl.sv
// Directed bench for pwl_lerp_ctrl: 4-entry table, behavioural lerp responder,
// scoreboard of expected responses checked with immediate assertions.
module tb_pwl_lerp_ctrl;

  localparam int S       = 32;
  localparam int N       = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [S-1:0]  wr_x, wr_y;
  logic          tbl_busy;
  logic          in_valid, in_ready;
  logic [S-1:0]  in_x;
  logic          out_valid, out_ready;
  logic [S-1:0]  out_y;
  logic [1:0]    out_flag;
  logic          out_tmo;
  logic          lerp_start;
  logic [S-1:0]  lerp_x1, lerp_x2, lerp_y1, lerp_y2, lerp_x;
  logic [S-1:0]  lerp_y;
  logic          lerp_done;

  pwl_lerp_ctrl #(.S(S), .N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .tbl_busy(tbl_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flag(out_flag), .out_tmo(out_tmo),
    .lerp_start(lerp_start), .lerp_x1(lerp_x1), .lerp_x2(lerp_x2),
    .lerp_y1(lerp_y1), .lerp_y2(lerp_y2), .lerp_x(lerp_x),
    .lerp_y(lerp_y), .lerp_done(lerp_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] y;
    logic [1:0]  flag;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  // Behavioural lerp unit: answers model_y four negedges after seeing the start pulse.
  logic        model_en = 1'b1;
  logic [31:0] model_y  = '0;
  int          n_starts = 0;
  int unsigned start_cyc = 0;
  logic [31:0] cap_x1, cap_x2, cap_y1, cap_y2, cap_x;

  always begin
    @(negedge clk);
    if (lerp_start) begin
      n_starts++;
      start_cyc = cyc;
      cap_x1 = lerp_x1; cap_x2 = lerp_x2;
      cap_y1 = lerp_y1; cap_y2 = lerp_y2; cap_x = lerp_x;
      if (model_en) begin
        repeat (4) @(negedge clk);
        lerp_y    = model_y;
        lerp_done = 1'b1;
        @(negedge clk);
        lerp_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input logic [31:0] y, input logic [1:0] flag, input logic tmo);
    exp_t e;
    e.y = y; e.flag = flag; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] x, input logic [31:0] y);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drives one query and returns the negedge count (from accept) at which out_valid is seen.
  task automatic send(input string tag, input logic [31:0] x, output int lat);
    int b;
    b = 0;
    while (!in_ready && b < 100) begin @(negedge clk); b++; end
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_x = x; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic recv(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_y"}, out_y, e.y);
      check({tag, "_flag"}, {30'b0, out_flag}, {30'b0, e.flag});
      check({tag, "_tmo"}, {31'b0, out_tmo}, {31'b0, e.tmo});
    end
    check({tag, "_busy"}, {31'b0, tbl_busy}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_ops(input string tag, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [31:0] y1, input logic [31:0] y2, input logic [31:0] x);
    check({tag, "_x1"}, cap_x1, x1);
    check({tag, "_x2"}, cap_x2, x2);
    check({tag, "_y1"}, cap_y1, y1);
    check({tag, "_y2"}, cap_y2, y2);
    check({tag, "_x"},  cap_x,  x);
  endtask

  initial begin
    int lat;
    int s0;
    logic saw_valid;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    lerp_y = '0; lerp_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   {31'b0, in_ready},   32'd1);
    check("rst_out_valid",  {31'b0, out_valid},  32'd0);
    check("rst_lerp_start", {31'b0, lerp_start}, 32'd0);
    check("rst_busy",       {31'b0, tbl_busy},   32'd0);
    check("rst_out_y",      out_y,               32'd0);
    check("rst_flag",       {30'b0, out_flag},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    wr(2'd0, 32'h0000_0000, 32'h0000_0000);
    wr(2'd1, 32'h3F80_0000, 32'h4000_0000);
    wr(2'd2, 32'h4000_0000, 32'h4040_0000);
    wr(2'd3, 32'h4080_0000, 32'h4040_0000);

    // Interior point 1.5 -> segment 1
    s0 = n_starts; model_y = 32'h4020_0000;
    expect_resp(32'h4020_0000, 2'b00, 1'b0);
    send("mid", 32'h3FC0_0000, lat);
    check("mid_starts", n_starts - s0, 1);
    check_ops("mid_op", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4040_0000, 32'h3FC0_0000);
    recv("mid");

    // Below table
    s0 = n_starts;
    expect_resp(32'h0000_0000, 2'b01, 1'b0);
    send("low", 32'hBF80_0000, lat);
    check("low_lat", lat, 2);
    check("low_starts", n_starts - s0, 0);
    recv("low");

    // Above table
    s0 = n_starts;
    expect_resp(32'h4040_0000, 2'b10, 1'b0);
    send("high", 32'h4100_0000, lat);
    check("high_lat", lat, 5);
    check("high_starts", n_starts - s0, 0);
    recv("high");

    // Exact breakpoint belongs to the segment it starts
    model_y = 32'h4040_0000;
    expect_resp(32'h4040_0000, 2'b00, 1'b0);
    send("exact", 32'h4000_0000, lat);
    check_ops("exact_op", 32'h4000_0000, 32'h4080_0000, 32'h4040_0000, 32'h4040_0000, 32'h4000_0000);
    recv("exact");

    // -0 equals +0 -> segment 0, interpolated
    model_y = 32'h0000_0000;
    expect_resp(32'h0000_0000, 2'b00, 1'b0);
    send("negz", 32'h8000_0000, lat);
    check_ops("negz_op", 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000);
    recv("negz");

    // NaN input
    s0 = n_starts;
    expect_resp(32'h7FC0_0000, 2'b11, 1'b0);
    send("nan", 32'h7FC0_0001, lat);
    check("nan_lat", lat, 1);
    check("nan_starts", n_starts - s0, 0);
    recv("nan");

    // Lerp never answers -> timeout after 16 WAIT cycles
    model_en = 1'b0;
    expect_resp(32'h7FC0_0000, 2'b11, 1'b1);
    send("tmo", 32'h3FC0_0000, lat);
    check("tmo_cycles", cyc - start_cyc, 32'd17);
    recv("tmo");
    model_en = 1'b1;

    // Backpressure: result held, input blocked, table writes dropped
    expect_resp(32'h0000_0000, 2'b01, 1'b0);
    send("hold", 32'hBF80_0000, lat);
    wr_en = 1'b1; wr_addr = 2'd3; wr_x = 32'h4100_0000; wr_y = 32'h4080_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_y", out_y, 32'h0000_0000);
      check("hold_flag", {30'b0, out_flag}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    wr_en = 1'b0;
    recv("hold");
    expect_resp(32'h4040_0000, 2'b10, 1'b0);
    send("dropwr", 32'h4100_0000, lat);
    recv("dropwr");

    // Write in IDLE takes effect
    wr(2'd3, 32'h4100_0000, 32'h4080_0000);
    expect_resp(32'h4080_0000, 2'b10, 1'b0);
    send("newhi", 32'h4100_0000, lat);
    recv("newhi");
    model_y = 32'h4060_0000;
    expect_resp(32'h4060_0000, 2'b00, 1'b0);
    send("newseg", 32'h40C0_0000, lat);
    check_ops("newseg_op", 32'h4000_0000, 32'h4100_0000, 32'h4040_0000, 32'h4080_0000, 32'h40C0_0000);
    recv("newseg");

    // Reset while waiting on lerp; its late done must be ignored
    s0 = n_starts; model_y = 32'h1234_5678;
    in_x = 32'h3FC0_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 50 && n_starts == s0; i++) @(negedge clk);
    check("rstw_started", n_starts - s0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_in_ready", {31'b0, in_ready}, 32'd1);
    check("rstw_busy", {31'b0, tbl_busy}, 32'd0);
    check("rstw_lerp_start", {31'b0, lerp_start}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rstw_stray_done", {31'b0, saw_valid}, 32'd0);
    s0 = n_starts;
    expect_resp(32'h0000_0000, 2'b10, 1'b0);
    send("zeroed", 32'h3FC0_0000, lat);
    check("zeroed_lat", lat, 5);
    check("zeroed_starts", n_starts - s0, 0);
    recv("zeroed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
